// File: rtl/serial_loader.sv
// Framed serial-to-parallel loader feeding an 8-bit register: start bit, LSB-first data, stop bit.
// Optional even-parity bit between data and stop when SERIAL_LOADER_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a start bit (sin=0) on a bit_en sample
// DATA   | shifting in width data bits, LSB first
// PARITY | checking the even-parity bit (SERIAL_LOADER_PARITY_EN only)
// STOP   | stop bit: 1 loads D and pulses we, 0 pulses ferr
module serial_loader #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             bit_en,
   output logic [width-1:0] D,
   output logic             we,
   output logic             busy,
   output logic             ferr
);

   localparam int cnt_w = $clog2(width + 1);
   localparam logic [cnt_w-1:0] last_idx = cnt_w'(width - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      STOP   = 2'd2,
      PARITY = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [cnt_w-1:0] cnt, cnt_nxt;
   logic [width-1:0] sreg, sreg_nxt;
   logic [width-1:0] d_nxt;
   logic             we_nxt, ferr_nxt;
   logic             par_err, par_err_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         sreg    <= '0;
         par_err <= 1'b0;
         D       <= '0;
         we      <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         sreg    <= sreg_nxt;
         par_err <= par_err_nxt;
         D       <= d_nxt;
         we      <= we_nxt;
         ferr    <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (bit_en) begin
         case (state)
            IDLE:    if (!sin) state_nxt = DATA;
            DATA: begin
               if (cnt == last_idx) begin
`ifdef SERIAL_LOADER_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // D only moves on a clean stop bit, so it never shows a partial word.
   always_comb begin
      cnt_nxt     = cnt;
      sreg_nxt    = sreg;
      par_err_nxt = par_err;
      d_nxt       = D;
      we_nxt      = 1'b0;
      ferr_nxt    = 1'b0;
      if (bit_en) begin
         case (state)
            IDLE: begin
               if (!sin) begin
                  cnt_nxt     = '0;
                  par_err_nxt = 1'b0;
               end
            end
            DATA: begin
               sreg_nxt = {sin, sreg[width-1:1]};
               cnt_nxt  = cnt + cnt_w'(1);
            end
`ifdef SERIAL_LOADER_PARITY_EN
            PARITY: par_err_nxt = (^sreg) ^ sin;
`endif
            STOP: begin
               if (sin && !par_err) begin
                  d_nxt  = sreg;
                  we_nxt = 1'b1;
               end else begin
                  ferr_nxt = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/serial_loader.md
Name: serial_loader

Overview:
- Deserializer that sits directly upstream of the 8-bit Register.
- Receives a framed serial bitstream one bit per enabled clock and assembles it into a parallel word.
- Drives the Register's D and we inputs: D holds the assembled word, and we pulses for exactly one cycle per valid frame.
- Flags framing errors so bad frames never reach the register.

Parameters:
- width, 8, data bits per frame; equals the downstream Register width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- sin  input  1  serial data in; idle level 1.
- bit_en  input  1  bit strobe; sin is sampled only on posedges where bit_en=1.
- D  output  width  assembled word; feeds Register.D.
- we  output  1  one-cycle write strobe; feeds Register.we.
- busy  output  1  1 while a frame is in progress (state != IDLE).
- ferr  output  1  one-cycle framing-error pulse.

Behaviour:
- Reset (rst=0, async): state=IDLE, D=0, we=0, busy=0, ferr=0, shift register=0, bit counter=0.
- Reset asserted mid-frame aborts the frame immediately. No we and no ferr are produced for the aborted frame.
- Posedges with bit_en=0:
  - state, counter and shift register hold.
  - we and ferr are forced to 0.
- FSM (transitions only on posedge with bit_en=1):
  - IDLE: sin=0 (start bit) -> DATA, counter=0. sin=1 -> stay IDLE.
  - DATA: shift sin in LSB-first (bit k lands at position k). Counter increments each sample. After the width-th sample -> STOP.
  - STOP, sin=1: D <= assembled word, we <= 1 for this one cycle, -> IDLE.
  - STOP, sin=0: D unchanged, we stays 0, ferr <= 1 for one cycle, -> IDLE.
- Timing and latency:
  - Registered outputs: we and D update on the same posedge that samples the stop bit.
  - we is high for exactly one clk cycle, regardless of the next bit_en.
  - A frame needs width+2 bit_en samples.
- Back-to-back frames: a start bit may be sampled on the first bit_en sample after STOP. No idle bit is required between frames.
- D holds its last valid word between frames. It is never partially updated while a frame is in progress.
- busy:
  - 1 from the posedge that samples the start bit through the posedge that samples the stop bit.
  - 0 from that posedge onward, i.e. busy=0 in the cycle where we=1.
- Counter width: enough bits to count 0..width, i.e. clog2(width+1). No wrap-around within a frame.

Optional Feature:
- Macro: SERIAL_LOADER_PARITY_EN.
- Defined:
  - An even-parity bit follows the data bits, so a frame is width+3 samples.
  - A PARITY state sits between DATA and STOP.
  - Parity mismatch: the stop bit is still consumed, then ferr=1 and we=0, D unchanged.
  - Stop=0 also gives ferr=1.
- Undefined: no parity state; frame format as above.

Test Plan:
- Reset: drive rst=0 mid-frame (after 3 data bits), release, then send a full frame of 0xA5 -> D=0x00 and we=0 during reset; after the frame D=0xA5 with a single we pulse.
- Basic frame: bit_en=1 every cycle, sin = 0, 1,0,1,0,0,1,0,1 (LSB first), 1 -> D=0xA5, we=1 for one cycle on the stop sample, busy=0 in that same cycle.
- Sparse strobe: bit_en high every 4th cycle, frame 0x3C -> D=0x3C, exactly one we pulse, no state change on bit_en=0 cycles.
- Framing error: frame 0xFF followed by stop bit 0 -> ferr=1 for one cycle, we=0, D keeps its previous 0x3C.
- Back-to-back: frames 0x01 then 0x80 with no idle gap -> two we pulses width+2 samples apart, D=0x01 then D=0x80. A downstream Register with the same clk captures Q=0x01 then Q=0x80.
- Parity (with SERIAL_LOADER_PARITY_EN defined): 0x07 with parity bit 1 -> we=1, D=0x07; 0x07 with parity bit 0 -> ferr=1, we=0.
